// File: rtl/mem_stage.sv
// RV32I memory stage: issues data-memory requests for loads/stores, stalls the
// front of the pipeline while an access is outstanding, and fills MEM/WB.

package mem_stage_pkg;

    localparam logic [6:0] op_lui   = 7'b0110111;
    localparam logic [6:0] op_auipc = 7'b0010111;
    localparam logic [6:0] op_jal   = 7'b1101111;
    localparam logic [6:0] op_jalr  = 7'b1100111;
    localparam logic [6:0] op_br    = 7'b1100011;
    localparam logic [6:0] op_load  = 7'b0000011;
    localparam logic [6:0] op_store = 7'b0100011;
    localparam logic [6:0] op_imm   = 7'b0010011;
    localparam logic [6:0] op_reg   = 7'b0110011;

    localparam logic [2:0] f3_b  = 3'b000;
    localparam logic [2:0] f3_h  = 3'b001;
    localparam logic [2:0] f3_w  = 3'b010;
    localparam logic [2:0] f3_bu = 3'b100;
    localparam logic [2:0] f3_hu = 3'b101;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] alu_out;
        logic [31:0] rs2_v;
        logic        regf_we;
        logic [3:0]  regfilemux_sel;
    } ex_mem_stage_reg_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] alu_out;
        logic [31:0] rs2_v;
        logic        regf_we;
        logic [3:0]  regfilemux_sel;
        logic [31:0] dmem_addr;
        logic [3:0]  dmem_rmask;
        logic [3:0]  dmem_wmask;
        logic [31:0] dmem_wdata;
    } mem_wb_stage_reg_t;

endpackage

// state   | meaning
// st_idle | no access outstanding; a legal load/store issues its request this cycle
// st_wait | request issued, waiting for dmem_resp; upstream frozen until it arrives
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  ex_mem_stage_reg_t ex_mem,
    output logic [31:0]       dmem_addr,
    output logic [3:0]        dmem_rmask,
    output logic [3:0]        dmem_wmask,
    output logic [31:0]       dmem_wdata,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp,
    output logic              mem_stall,
    output mem_wb_stage_reg_t mem_wb,
    output logic [31:0]       mem_rdata
);

    typedef enum logic {
        st_idle,
        st_wait
    } state_t;

    state_t      state;

    logic [1:0]  off;
    logic        is_load;
    logic        is_store;
    logic        aligned;
    logic        mem_op;
    logic        issue;
    logic [3:0]  base_mask;
    logic [3:0]  lane_mask;
    logic [31:0] cur_addr;
    logic [3:0]  cur_rmask;
    logic [3:0]  cur_wmask;
    logic [31:0] cur_wdata;

    logic [31:0] req_addr;
    logic [3:0]  req_rmask;
    logic [3:0]  req_wmask;
    logic [31:0] req_wdata;

    assign off      = ex_mem.alu_out[1:0];
    assign is_load  = (ex_mem.opcode == op_load);
    assign is_store = (ex_mem.opcode == op_store);

    // Unsigned widths exist only for loads; any other funct3 is treated as no access.
    always_comb begin
        base_mask = 4'b0000;
        aligned   = 1'b0;
        case (ex_mem.funct3)
            f3_b: begin
                base_mask = 4'b0001;
                aligned   = is_load | is_store;
            end
            f3_h: begin
                base_mask = 4'b0011;
                aligned   = (is_load | is_store) & ~off[0];
            end
            f3_w: begin
                base_mask = 4'b1111;
                aligned   = (is_load | is_store) & (off == 2'b00);
            end
            f3_bu: begin
                base_mask = 4'b0001;
                aligned   = is_load;
            end
            f3_hu: begin
                base_mask = 4'b0011;
                aligned   = is_load & ~off[0];
            end
            default: begin
                base_mask = 4'b0000;
                aligned   = 1'b0;
            end
        endcase
    end

    assign mem_op    = ex_mem.valid & aligned;
    assign lane_mask = base_mask << off;
    assign cur_addr  = {ex_mem.alu_out[31:2], 2'b00};
    assign cur_rmask = is_load  ? lane_mask : 4'b0000;
    assign cur_wmask = is_store ? lane_mask : 4'b0000;
    assign cur_wdata = ex_mem.rs2_v << {off, 3'b000};

    assign issue = ~rst & (state == st_idle) & mem_op;

    assign dmem_addr  = issue ? cur_addr  : 32'h0;
    assign dmem_rmask = issue ? cur_rmask : 4'h0;
    assign dmem_wmask = issue ? cur_wmask : 4'h0;
    assign dmem_wdata = issue ? cur_wdata : 32'h0;

    assign mem_stall = ~rst & ((state == st_idle) ? mem_op : ~dmem_resp);

    function automatic mem_wb_stage_reg_t to_wb(
        input ex_mem_stage_reg_t e,
        input logic [31:0]       a,
        input logic [3:0]        rm,
        input logic [3:0]        wm,
        input logic [31:0]       wd
    );
        mem_wb_stage_reg_t w;
        w.valid          = e.valid;
        w.pc             = e.pc;
        w.inst           = e.inst;
        w.opcode         = e.opcode;
        w.funct3         = e.funct3;
        w.rd_addr        = e.rd_addr;
        w.rs1_addr       = e.rs1_addr;
        w.rs2_addr       = e.rs2_addr;
        w.alu_out        = e.alu_out;
        w.rs2_v          = e.rs2_v;
        w.regf_we        = e.regf_we;
        w.regfilemux_sel = e.regfilemux_sel;
        w.dmem_addr      = a;
        w.dmem_rmask     = rm;
        w.dmem_wmask     = wm;
        w.dmem_wdata     = wd;
        return w;
    endfunction

    // While stalled only valid drops, so WB sees bubbles and nothing retires twice.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= st_idle;
            mem_wb    <= '0;
            mem_rdata <= 32'h0;
            req_addr  <= 32'h0;
            req_rmask <= 4'h0;
            req_wmask <= 4'h0;
            req_wdata <= 32'h0;
        end else begin
            case (state)
                st_idle: begin
                    if (mem_op) begin
                        req_addr     <= cur_addr;
                        req_rmask    <= cur_rmask;
                        req_wmask    <= cur_wmask;
                        req_wdata    <= cur_wdata;
                        mem_wb.valid <= 1'b0;
                        state        <= st_wait;
                    end else begin
                        mem_wb <= to_wb(ex_mem, 32'h0, 4'h0, 4'h0, 32'h0);
                    end
                end
                st_wait: begin
                    if (dmem_resp) begin
                        mem_wb    <= to_wb(ex_mem, req_addr, req_rmask, req_wmask, req_wdata);
                        mem_rdata <= dmem_rdata;
                        state     <= st_idle;
                    end else begin
                        mem_wb.valid <= 1'b0;
                    end
                end
                default: state <= st_idle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: random and directed ops against a byte-lane
// reference model, with a latency-randomising data-memory responder.

module tb_mem_stage;
    import mem_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    ex_mem_stage_reg_t ex_mem;
    logic [31:0]       dmem_addr;
    logic [3:0]        dmem_rmask;
    logic [3:0]        dmem_wmask;
    logic [31:0]       dmem_wdata;
    logic [31:0]       dmem_rdata;
    logic              dmem_resp;
    logic              mem_stall;
    mem_wb_stage_reg_t mem_wb;
    logic [31:0]       mem_rdata;

    mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .ex_mem     (ex_mem),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_stall  (mem_stall),
        .mem_wb     (mem_wb),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_wb_stage_reg_t wb;
        logic [31:0]       rd;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] wd;
    } req_t;

    exp_t        exp_q[$];
    req_t        req_q[$];
    int          vectors = 0;
    int          errors  = 0;
    bit          manual  = 1'b1;
    int          force_lat = 0;
    logic [31:0] ref_mem [16];
    logic [31:0] phys_mem[16];
    logic [31:0] last_rdata = 32'h0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: access size from funct3, legal only if offset is a multiple of size.
    function automatic void model_req(input ex_mem_stage_reg_t op, output bit is_mem,
                                      output logic [31:0] a, output logic [3:0] rm,
                                      output logic [3:0] wm, output logic [31:0] wd);
        int  size;
        int  off;
        bit  ld;
        bit  st;
        bit  legal;
        logic [7:0] m8;
        ld  = (op.opcode == op_load);
        st  = (op.opcode == op_store);
        off = int'(op.alu_out[1:0]);
        case (op.funct3)
            3'd0:    begin size = 1; legal = ld || st; end
            3'd1:    begin size = 2; legal = ld || st; end
            3'd2:    begin size = 4; legal = ld || st; end
            3'd4:    begin size = 1; legal = ld; end
            3'd5:    begin size = 2; legal = ld; end
            default: begin size = 1; legal = 1'b0; end
        endcase
        is_mem = op.valid && legal && ((off % size) == 0);
        m8 = 8'(((1 << size) - 1) << off);
        a  = op.alu_out & 32'hFFFF_FFFC;
        rm = (is_mem && ld) ? m8[3:0] : 4'h0;
        wm = (is_mem && st) ? m8[3:0] : 4'h0;
        wd = is_mem ? (op.rs2_v << (8 * off)) : 32'h0;
        if (!is_mem) a = 32'h0;
    endfunction

    function automatic ex_mem_stage_reg_t mk(input logic [6:0] opc, input logic [2:0] f3,
                                             input logic [31:0] alu, input logic [31:0] rs2v);
        ex_mem_stage_reg_t o;
        o.valid          = 1'b1;
        o.pc             = $urandom;
        o.inst           = $urandom;
        o.opcode         = opc;
        o.funct3         = f3;
        o.rd_addr        = 5'($urandom);
        o.rs1_addr       = 5'($urandom);
        o.rs2_addr       = 5'($urandom);
        o.alu_out        = alu;
        o.rs2_v          = rs2v;
        o.regf_we        = 1'($urandom);
        o.regfilemux_sel = 4'($urandom);
        return o;
    endfunction

    task automatic drive_op(input ex_mem_stage_reg_t op);
        bit          m;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  rm;
        logic [3:0]  wm;
        exp_t        e;
        req_t        r;
        int          g;
        model_req(op, m, a, rm, wm, wd);
        @(negedge clk);
        ex_mem = op;
        if (m) begin
            r.a = a; r.rm = rm; r.wm = wm; r.wd = wd;
            req_q.push_back(r);
            last_rdata = ref_mem[a[5:2]];
            for (int b = 0; b < 4; b++)
                if (wm[b]) ref_mem[a[5:2]][8*b +: 8] = wd[8*b +: 8];
        end
        if (op.valid) begin
            e.wb.valid          = 1'b1;
            e.wb.pc             = op.pc;
            e.wb.inst           = op.inst;
            e.wb.opcode         = op.opcode;
            e.wb.funct3         = op.funct3;
            e.wb.rd_addr        = op.rd_addr;
            e.wb.rs1_addr       = op.rs1_addr;
            e.wb.rs2_addr       = op.rs2_addr;
            e.wb.alu_out        = op.alu_out;
            e.wb.rs2_v          = op.rs2_v;
            e.wb.regf_we        = op.regf_we;
            e.wb.regfilemux_sel = op.regfilemux_sel;
            e.wb.dmem_addr      = a;
            e.wb.dmem_rmask     = rm;
            e.wb.dmem_wmask     = wm;
            e.wb.dmem_wdata     = wd;
            e.rd                = last_rdata;
            exp_q.push_back(e);
        end
        g = 0;
        #3;
        while (mem_stall && g < 50) begin
            @(negedge clk);
            #3;
            g++;
        end
        if (mem_stall) begin
            vectors++;
            errors++;
            $display("FAIL stall_timeout: mem_stall still %0b after %0d cycles, required 0", mem_stall, g);
        end
    endtask

    // Responder: answers each request after N cycles and checks stall/quiet outputs meanwhile.
    initial begin : responder
        int          cnt;
        int          widx;
        logic [3:0]  cur_wm;
        logic [31:0] cur_wd;
        req_t        r;
        cnt = 0; widx = 0; cur_wm = 4'h0; cur_wd = 32'h0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (manual) begin
                cnt = 0;
                continue;
            end
            if (cnt == 1) begin
                dmem_resp  = 1'b1;
                dmem_rdata = phys_mem[widx];
            end else if (cnt > 1) begin
                dmem_resp  = 1'b0;
                dmem_rdata = $urandom;
            end else begin
                dmem_resp  = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
            #3;
            if (cnt > 0) begin
                chk("wait_masks", 256'({dmem_rmask, dmem_wmask}), 256'(0));
                chk("wait_stall", 256'(mem_stall), 256'(cnt > 1));
                if (cnt == 1)
                    for (int b = 0; b < 4; b++)
                        if (cur_wm[b]) phys_mem[widx][8*b +: 8] = cur_wd[8*b +: 8];
                cnt--;
            end else if (dmem_rmask != 4'h0 || dmem_wmask != 4'h0) begin
                if (req_q.size() == 0) begin
                    vectors++;
                    errors++;
                    $display("FAIL unexpected_req: addr %0h rmask %0h wmask %0h, required no request",
                             dmem_addr, dmem_rmask, dmem_wmask);
                end else begin
                    r = req_q.pop_front();
                    chk("req_fields", 256'({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata}),
                        256'({r.a, r.rm, r.wm, r.wd}));
                end
                chk("issue_stall", 256'(mem_stall), 256'(1));
                widx   = int'(dmem_addr[5:2]);
                cur_wm = dmem_wmask;
                cur_wd = dmem_wdata;
                cnt    = (force_lat != 0) ? force_lat : $urandom_range(1, 4);
            end else begin
                chk("idle_stall", 256'(mem_stall), 256'(0));
                chk("idle_addr", 256'({dmem_addr, dmem_wdata}), 256'(0));
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mem_wb.valid) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_retire: pc %0h retired, required no retirement", mem_wb.pc);
            end else begin
                e = exp_q.pop_front();
                chk("mem_wb", 256'(mem_wb), 256'(e.wb));
                chk("mem_rdata", 256'(mem_rdata), 256'(e.rd));
            end
        end
    end

    initial begin
        int g;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i]  = $urandom;
            phys_mem[i] = ref_mem[i];
        end
        ref_mem[1]  = 32'hDEAD_BEEF;
        phys_mem[1] = 32'hDEAD_BEEF;

        // Reset with a load presented: nothing may issue or stall.
        rst    = 1'b1;
        ex_mem = mk(op_load, f3_w, 32'h1000_0004, 32'h0);
        @(negedge clk);
        #3;
        chk("rst_stall", 256'(mem_stall), 256'(0));
        chk("rst_req", 256'({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata}), 256'(0));
        @(posedge clk);
        #1;
        chk("rst_mem_wb", 256'(mem_wb), 256'(0));
        chk("rst_mem_rdata", 256'(mem_rdata), 256'(0));
        @(negedge clk);
        rst    = 1'b0;
        ex_mem = '0;
        @(posedge clk);
        #1;
        manual = 1'b0;

        force_lat = 3;
        drive_op(mk(op_load, f3_w, 32'h1000_0004, 32'h0));
        force_lat = 0;
        drive_op(mk(op_store, f3_b, 32'h2000_0003, 32'h0000_00AB));
        drive_op(mk(op_store, f3_h, 32'h1000_0012, 32'h0000_1234));
        drive_op(mk(op_load, f3_h, 32'h1000_0011, 32'h0));
        drive_op(mk(op_reg, 3'd0, 32'h0000_0055, 32'h7));
        drive_op('0);
        drive_op(mk(op_imm, 3'd0, 32'h1000_0002, 32'h9));
        force_lat = 1;
        drive_op(mk(op_load, f3_w, 32'h1000_0008, 32'h0));
        drive_op(mk(op_store, f3_w, 32'h1000_0008, 32'hCAFE_F00D));
        drive_op(mk(op_load, f3_bu, 32'h1000_000B, 32'h0));
        force_lat = 0;

        for (int n = 0; n < 300; n++) begin
            ex_mem_stage_reg_t o;
            logic [6:0] opc;
            case ($urandom_range(0, 3))
                0:       opc = op_load;
                1:       opc = op_store;
                2:       opc = op_reg;
                default: opc = op_imm;
            endcase
            o = mk(opc, 3'($urandom_range(0, 7)), 32'h1000_0000 + $urandom_range(0, 63), $urandom);
            o.valid = ($urandom_range(0, 9) != 0);
            drive_op(o);
        end

        @(negedge clk);
        ex_mem = '0;
        g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(posedge clk);
            #2;
            g++;
        end
        repeat (2) @(posedge clk);
        #2;
        manual    = 1'b1;
        dmem_resp = 1'b0;

        // Reset while waiting on a load, then a stray response afterwards.
        @(negedge clk);
        ex_mem = mk(op_load, f3_w, 32'h1000_0004, 32'h0);
        #3;
        chk("rw_issue", 256'({dmem_addr, dmem_rmask, mem_stall}), 256'({32'h1000_0004, 4'hF, 1'b1}));
        @(negedge clk);
        #3;
        chk("rw_wait_stall", 256'(mem_stall), 256'(1));
        @(negedge clk);
        rst = 1'b1;
        #3;
        chk("rw_rst_stall", 256'(mem_stall), 256'(0));
        chk("rw_rst_req", 256'({dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata}), 256'(0));
        @(posedge clk);
        #1;
        chk("rw_rst_mem_wb", 256'(mem_wb), 256'(0));
        chk("rw_rst_rdata", 256'(mem_rdata), 256'(0));
        @(negedge clk);
        rst    = 1'b0;
        ex_mem = '0;
        #3;
        chk("rw_post_stall", 256'(mem_stall), 256'(0));
        @(negedge clk);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        #3;
        chk("rw_stray_stall", 256'(mem_stall), 256'(0));
        @(negedge clk);
        dmem_resp = 1'b0;
        #3;
        chk("rw_stray_mem_wb", 256'(mem_wb), 256'(0));
        chk("rw_stray_rdata", 256'(mem_rdata), 256'(0));
        chk("rw_stray_req", 256'({dmem_rmask, dmem_wmask, mem_stall}), 256'(0));

        chk("exp_q_empty", 256'(exp_q.size()), 256'(0));
        chk("req_q_empty", 256'(req_q.size()), 256'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

endmodule
